// File: rtl/pwm_generator.sv
// PWM generator: a four-state controller that drives an external timer through restart.
// It produces a registered waveform, per-period pulses and a double-buffered configuration.
module pwm_generator #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [WORD_WIDTH-1:0] count,
  output logic                  restart,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [WORD_WIDTH-1:0] cfg_period,
  input  logic [WORD_WIDTH-1:0] cfg_duty,
  input  logic [WORD_WIDTH-1:0] cfg_num,
  input  logic                  start,
  input  logic                  stop,
  output logic                  pwm_out,
  output logic                  period_done,
  output logic                  busy,
  output logic [WORD_WIDTH-1:0] period_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN
  } state_e;

  localparam logic [WORD_WIDTH-1:0] ONES = '1;
  localparam logic [WORD_WIDTH-1:0] ONE  = WORD_WIDTH'(1);
  localparam logic [WORD_WIDTH-1:0] TWO  = WORD_WIDTH'(2);

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] period_act_q, period_act_d;
  logic [WORD_WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WORD_WIDTH-1:0] num_act_q, num_act_d;
  logic [WORD_WIDTH-1:0] period_sh_q, period_sh_d;
  logic [WORD_WIDTH-1:0] duty_sh_q, duty_sh_d;
  logic [WORD_WIDTH-1:0] num_sh_q, num_sh_d;
  logic                  shadow_pending_q, shadow_pending_d;
  logic                  cfg_loaded_q, cfg_loaded_d;
  logic                  pwm_out_q, pwm_out_d;
  logic                  period_done_q, period_done_d;
  logic [WORD_WIDTH-1:0] period_cnt_q, period_cnt_d;

  logic                  active;
  logic                  boundary;
  logic                  terminate;
  logic                  cfg_fire;
  logic [WORD_WIDTH-1:0] cfg_period_clamped;

  always_comb begin
    active    = (state_q == S_RUN) || (state_q == S_DRAIN);
    boundary  = active && (count == period_act_q - ONE);
    terminate = (num_act_q != '0) && (period_cnt_q + ONE == num_act_q);
    restart   = !rstn || !active || boundary;
    cfg_ready = !rstn || (state_q == S_IDLE) || !shadow_pending_q;
    busy      = rstn && (state_q != S_IDLE);
    cfg_fire  = cfg_valid && cfg_ready;
    cfg_period_clamped = (cfg_period < TWO) ? TWO : cfg_period;
  end

  always_comb begin
    state_d          = state_q;
    period_act_d     = period_act_q;
    duty_act_d       = duty_act_q;
    num_act_d        = num_act_q;
    period_sh_d      = period_sh_q;
    duty_sh_d        = duty_sh_q;
    num_sh_d         = num_sh_q;
    shadow_pending_d = shadow_pending_q;
    cfg_loaded_d     = cfg_loaded_q;
    period_cnt_d     = period_cnt_q;
    period_done_d    = boundary;
    pwm_out_d        = active && (count < duty_act_q);

    if (boundary) begin
      if (period_cnt_q != ONES) begin
        period_cnt_d = period_cnt_q + ONE;
      end
      if (shadow_pending_q) begin
        period_act_d     = period_sh_q;
        duty_act_d       = duty_sh_q;
        num_act_d        = num_sh_q;
        shadow_pending_d = 1'b0;
      end
    end

    // Idle configs go live at once; busy configs wait for a period boundary.
    if (cfg_fire) begin
      if (state_q == S_IDLE) begin
        period_act_d = cfg_period_clamped;
        duty_act_d   = cfg_duty;
        num_act_d    = cfg_num;
        cfg_loaded_d = 1'b1;
      end else begin
        period_sh_d      = cfg_period_clamped;
        duty_sh_d        = cfg_duty;
        num_sh_d         = cfg_num;
        shadow_pending_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && (cfg_loaded_q || cfg_fire)) begin
          state_d      = S_ARM;
          period_cnt_d = '0;
        end
      end
      S_ARM: begin
        state_d = stop ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (boundary && terminate) begin
          state_d = S_IDLE;
        end else if (stop) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (boundary) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q          <= S_IDLE;
      period_act_q     <= '0;
      duty_act_q       <= '0;
      num_act_q        <= '0;
      period_sh_q      <= '0;
      duty_sh_q        <= '0;
      num_sh_q         <= '0;
      shadow_pending_q <= 1'b0;
      cfg_loaded_q     <= 1'b0;
      pwm_out_q        <= 1'b0;
      period_done_q    <= 1'b0;
      period_cnt_q     <= '0;
    end else begin
      state_q          <= state_d;
      period_act_q     <= period_act_d;
      duty_act_q       <= duty_act_d;
      num_act_q        <= num_act_d;
      period_sh_q      <= period_sh_d;
      duty_sh_q        <= duty_sh_d;
      num_sh_q         <= num_sh_d;
      shadow_pending_q <= shadow_pending_d;
      cfg_loaded_q     <= cfg_loaded_d;
      pwm_out_q        <= pwm_out_d;
      period_done_q    <= period_done_d;
      period_cnt_q     <= period_cnt_d;
    end
  end

  assign pwm_out     = pwm_out_q;
  assign period_done = period_done_q;
  assign period_cnt  = period_cnt_q;

endmodule

// File: doc/pwm_generator.md
PWM_GENERATOR -- requirements
Module: pwm_generator

Interface
REQ-001 Parameter WORD_WIDTH, default 32, width of count, period, duty and period counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 count  input  WORD_WIDTH  free-running timer value; timer clears to 0 on the edge after restart is high, otherwise increments.
REQ-005 restart  output  1  timer clear request (combinational from state, count and active period).
REQ-006 cfg_valid  input  1  configuration offer.
REQ-007 cfg_ready  output  1  configuration accept; transfer when cfg_valid and cfg_ready are both high.
REQ-008 cfg_period, cfg_duty, cfg_num  input  WORD_WIDTH each  period length (cycles), high time (cycles), periods to run (0 = continuous).
REQ-009 start, stop  input  1 each  single-cycle control requests.
REQ-010 pwm_out  output  1  registered PWM waveform.
REQ-011 period_done  output  1  registered one-cycle pulse per completed period.
REQ-012 busy  output  1  high in ARM, RUN, DRAIN.
REQ-013 period_cnt  output  WORD_WIDTH  periods completed since last accepted start, saturating at all-ones.

Function
REQ-014 FSM states IDLE, ARM, RUN, DRAIN.
REQ-015 Active registers period_act, duty_act, num_act; shadow registers plus shadow_pending flag; cfg_loaded flag.
REQ-016 Accepted cfg_period below 2 is stored as 2.
REQ-017 IDLE: cfg_ready=1; accepted config writes active registers directly and sets cfg_loaded.
REQ-018 ARM/RUN/DRAIN: cfg_ready = not shadow_pending; accepted config writes shadow registers and sets shadow_pending.
REQ-019 IDLE to ARM on start with cfg_loaded set, or with a config accepted in the same cycle (new config used); start otherwise ignored.
REQ-020 Accepted start clears period_cnt to 0.
REQ-021 ARM lasts exactly one cycle, then RUN; count is 0 in first RUN cycle.
REQ-022 restart = 1 in IDLE and ARM; in RUN/DRAIN restart = (count == period_act - 1).
REQ-023 Boundary cycle = RUN/DRAIN cycle with count == period_act - 1; period length is exactly period_act cycles.
REQ-024 At a boundary: period_done asserts next cycle; period_cnt increments (saturating); if shadow_pending, active registers load from shadow and shadow_pending clears.
REQ-025 pwm_out next value = (state is RUN or DRAIN) and (count < duty_act); one-cycle latency from count; duty_act 0 gives constant low, duty_act >= period_act constant high.
REQ-026 RUN to IDLE at a boundary when num_act != 0 and period_cnt + 1 == num_act.
REQ-027 stop in ARM returns to IDLE; stop in RUN moves to DRAIN; DRAIN finishes current period and enters IDLE at its boundary; stop ignored in IDLE and DRAIN.
REQ-028 stop and a terminating boundary in the same cycle: enter IDLE.
REQ-029 start while busy is ignored.
REQ-030 Shadow loaded at the final boundary stays applied to active registers on IDLE entry.

Reset
REQ-031 rstn low at a clock edge: state IDLE, pwm_out 0, period_done 0, period_cnt 0, all active/shadow registers 0, cfg_loaded 0, shadow_pending 0.
REQ-032 During reset restart reads 1, cfg_ready 1, busy 0.
REQ-033 Reset mid-operation takes effect on the next edge regardless of state; no period_done issued for the interrupted period.

Verification
REQ-034 Config period=10, duty=3, num=0, start -> restart low after ARM, pwm_out high 3 of every 10 cycles, period_done every 10 cycles, period_cnt 1,2,3...
REQ-035 period=5, duty=2, num=3, start -> exactly 3 period_done pulses, period_cnt=3, then IDLE, busy 0, restart 1.
REQ-036 Running period=8 duty=2; mid-period config period=4 duty=4 -> current period completes at 8 cycles, next periods 4 cycles with pwm_out constant high; cfg_ready low until boundary.
REQ-037 period=1 duty=0 -> period clamped to 2, pwm_out constant low, period_done every 2 cycles.
REQ-038 Running period=10; stop at count 4 -> DRAIN, IDLE after count 9, one final period_done, period_cnt retained.
REQ-039 rstn low at count 6 in RUN -> next cycle all outputs at reset values; start without new config ignored (cfg_loaded 0).
